pc_fetch_unit: RTL
==================

# pc_fetch_unit

Fetch stage of the five-stage pipeline. Owns the program counter and the IF/ID pipeline register, and consumes the next-PC value computed in ID. Each unstalled clock it loads the PC from NPC and forwards the current PC/instruction pair to ID. It also drives the instruction-memory word address, squashes fetches from illegal addresses, and keeps a retired-fetch counter plus a sticky fault record for debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0
- IM_AW, 12, instruction-memory word-address width (IM_WORDS = 2^IM_AW)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- Stall  in  1  from hazard unit; 1 = hold PC and IF/ID
- NPC  in  32  next PC from ID-stage next-PC logic (branch/jal/jr target or IF_PC+4)
- IM_Instr  in  32  instruction word read combinationally at IM_Addr
- IF_PC  out  32  current fetch PC (registered)
- IM_Addr  out  IM_AW  (IF_PC − IM_BASE) >> 2, truncated to IM_AW bits
- ID_PC  out  32  PC of instruction in ID
- ID_Instr  out  32  instruction in ID
- ID_Valid  out  1  1 = ID_Instr is a real fetch, 0 = bubble
- Fault  out  1  sticky: an illegal PC has been fetched since reset
- Fault_PC  out  32  first illegal PC captured
- Fetch_Count  out  32  number of valid instructions delivered to ID

## Operation
- Illegal PC (combinational on IF_PC): IF_PC[1:0] != 0, or IF_PC < IM_BASE, or IF_PC ≥ IM_BASE + 4·2^IM_AW (compare in 33 bits, no wrap).
- Advance (rising edge, reset=0, Stall=0):
  - IF_PC <= NPC (any value accepted; legality checked on the next fetch).
  - ID_PC <= IF_PC.
  - Legal IF_PC: ID_Instr <= IM_Instr, ID_Valid <= 1, Fetch_Count <= Fetch_Count+1, saturating at 32'hFFFF_FFFF.
  - Illegal IF_PC: ID_Instr <= 32'h0000_0000 (nop), ID_Valid <= 0, Fetch_Count holds. If Fault=0: Fault <= 1 and Fault_PC <= IF_PC. If Fault=1: Fault_PC holds.
- Hold (Stall=1): all registers keep their values. No count change and no fault capture, even if IF_PC is illegal.
- Architecture uses a branch delay slot. The block never flushes IF/ID; the instruction after a branch always enters ID.
- IM_Addr is pure combinational from IF_PC. Its value is don't-care when IF_PC is illegal.

## Timing
- Reset (async assert, any time including mid-stall): IF_PC=RESET_PC, ID_PC=0, ID_Instr=0, ID_Valid=0, Fault=0, Fault_PC=0, Fetch_Count=0. Reset has priority over Stall.
- First edge after reset release with Stall=0: ID_PC=RESET_PC, and IF_PC takes NPC (normally RESET_PC+4).
- Latency: NPC to IF_PC is 1 cycle. IF_PC/IM_Instr to ID_PC/ID_Instr is 1 cycle. A redirect presented on NPC while the branch is in ID appears on IF_PC one edge later.
- Stall asserted on cycle n: outputs on cycle n+1 equal those on cycle n. The NPC value in cycle n is discarded, and the hazard unit re-presents it.
- Counter saturation: at 32'hFFFF_FFFF, further valid fetches leave it unchanged.

## Test plan
- Reset then 4 unstalled cycles with NPC=IF_PC+4 and IM_Instr=PC-tagged words: IF_PC 0x3000→0x3004→0x3008→0x300C; ID_PC trails by one; IM_Addr 0,1,2,3; Fetch_Count=4.
- Taken branch: while ID_PC=0x3004, drive NPC=0x3040. Delay-slot instruction 0x3008 still enters ID. The next ID_PC is 0x3040, and IM_Addr=0x10 in that fetch cycle.
- Stall 3 cycles mid-stream with a changing NPC: IF_PC, ID_PC, ID_Instr and Fetch_Count are frozen. Release resumes from the NPC presented on the release cycle.
- Illegal fetches: jr to 0x3002, then advance. Result: ID_Instr=0, ID_Valid=0, Fault=1, Fault_PC=0x3002. A later jr to 0x2FFC leaves Fault_PC=0x3002. An illegal PC held under Stall sets no fault.
- Upper bound: IF_PC=0x6FFC is legal (IM_Addr=0xFFF). IF_PC=0x7000 is illegal and squashed.
- Async reset asserted mid-cycle during Stall with Fault=1: all outputs reach reset values before the next edge. Force Fetch_Count near 32'hFFFF_FFFE, run 3 valid fetches, and confirm it saturates at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC and the IF/ID register, screens out illegal fetch
// addresses, and keeps a saturating fetch counter and a sticky fault record.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic [31:0]      NPC,
    input  logic [31:0]      IM_Instr,
    output logic [31:0]      IF_PC,
    output logic [IM_AW-1:0] IM_Addr,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_Instr,
    output logic             ID_Valid,
    output logic             Fault,
    output logic [31:0]      Fault_PC,
    output logic [31:0]      Fetch_Count
);

    // The upper bound is compared in 33 bits so a window ending at 2^32 cannot wrap.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'd4 << IM_AW);

    logic [31:0] pc_offset;
    logic        illegal_pc;

    always_comb begin
        pc_offset  = IF_PC - IM_BASE;
        IM_Addr    = pc_offset[IM_AW+1:2];
        illegal_pc = (IF_PC[1:0] != 2'b00) ||
                     (IF_PC < IM_BASE) ||
                     ({1'b0, IF_PC} >= IM_END);
    end

    // PC and IF/ID register; the delay slot means IF/ID is never flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IF_PC    <= RESET_PC;
            ID_PC    <= 32'h0000_0000;
            ID_Instr <= 32'h0000_0000;
            ID_Valid <= 1'b0;
        end else if (!Stall) begin
            IF_PC <= NPC;
            ID_PC <= IF_PC;
            if (illegal_pc) begin
                ID_Instr <= 32'h0000_0000;
                ID_Valid <= 1'b0;
            end else begin
                ID_Instr <= IM_Instr;
                ID_Valid <= 1'b1;
            end
        end
    end

    // Debug state: only the first illegal fetch is recorded until the next reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Fault       <= 1'b0;
            Fault_PC    <= 32'h0000_0000;
            Fetch_Count <= 32'h0000_0000;
        end else if (!Stall) begin
            if (illegal_pc) begin
                if (!Fault) begin
                    Fault    <= 1'b1;
                    Fault_PC <= IF_PC;
                end
            end else if (Fetch_Count != 32'hFFFF_FFFF) begin
                Fetch_Count <= Fetch_Count + 32'd1;
            end
        end
    end

endmodule
